// File: rtl/load_unit.sv
// RV32I load unit: takes a load request, issues one word-aligned read, then extracts and extends the addressed byte, halfword or word.
// Latency: mem_re one cycle after accept; response one cycle after mem_rvalid, and one cycle after accept for misaligned/illegal loads.
// Backpressure: one load in flight; req_ready stays low until the response handshakes; response fields hold while resp_ready is low.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      load request handshake carrying instr and daddr
//   mem_re, mem_addr         one-cycle read strobe and word-aligned address
//   mem_rvalid, mem_rdata    read data return (little-endian word)
//   resp_valid/resp_ready    response handshake to writeback
//   resp_data, resp_rd       extended load result and destination register
//   resp_err, resp_err_code  fault flag; 01 misaligned, 10 illegal funct3, 11 timeout
module load_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] instr,
    input  logic [31:0] daddr,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [1:0]  resp_err_code
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESP     = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;
    logic        accept;
    logic [2:0]  req_f3;
    logic        f3_illegal;
    logic        misaligned;
    logic        timeout_hit;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;
    logic        unused_instr;

    // Only funct3 and rd are meaningful to this unit.
    assign unused_instr = ^{instr[31:15], instr[6:0]};

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state == RESP);
    assign req_f3      = instr[14:12];
    assign timeout_hit = (cnt == CNT_LAST);

    // Illegal funct3 takes priority over misalignment.
    assign f3_illegal = (req_f3 == 3'b011) || (req_f3 == 3'b110) || (req_f3 == 3'b111);
    assign misaligned = (((req_f3 == 3'b001) || (req_f3 == 3'b101)) && daddr[0])
                     || ((req_f3 == 3'b010) && (daddr[1:0] != 2'b00));

    // Lane selection from the latched byte offset.
    always_comb begin
        sel_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
    end

    assign sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext_data = '0;
        case (funct3_q)
            3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ext_data = {24'h0, sel_byte};
            3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  ext_data = {16'h0, sel_half};
            3'b010:  ext_data = mem_rdata;
            default: ext_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (f3_illegal || misaligned) ? RESP : WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // Data arriving on the timeout cycle still completes normally.
                if (mem_rvalid || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q      <= '0;
            off_q         <= '0;
            cnt           <= '0;
            mem_re        <= 1'b0;
            mem_addr      <= '0;
            resp_data     <= '0;
            resp_rd       <= '0;
            resp_err      <= 1'b0;
            resp_err_code <= '0;
        end else begin
            mem_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= req_f3;
                        off_q    <= daddr[1:0];
                        resp_rd  <= instr[11:7];
                        if (f3_illegal) begin
                            resp_err      <= 1'b1;
                            resp_err_code <= 2'b10;
                            resp_data     <= '0;
                        end else if (misaligned) begin
                            resp_err      <= 1'b1;
                            resp_err_code <= 2'b01;
                            resp_data     <= '0;
                        end else begin
                            mem_addr <= {daddr[31:2], 2'b00};
                            mem_re   <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        resp_data     <= ext_data;
                        resp_err      <= 1'b0;
                        resp_err_code <= 2'b00;
                    end else if (timeout_hit) begin
                        resp_data     <= '0;
                        resp_err      <= 1'b1;
                        resp_err_code <= 2'b11;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Load-side counterpart of the store byte-enable path in the RV32I datapath.
- Accepts a load request (instr, daddr) from the execute stage and issues a word-aligned read to data memory.
- Waits for read data, extracts the addressed byte, halfword or word, and sign- or zero-extends it.
- Returns the result to writeback through a valid/ready handshake. Misaligned, illegal and timed-out loads are flagged.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in WAIT_MEM without mem_rvalid before the load is aborted with a timeout error (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  load request valid
req_ready  output  1  unit can accept a request
instr  input  32  load instruction; funct3 = instr[14:12], rd = instr[11:7]
daddr  input  32  effective byte address
mem_re  output  1  memory read strobe, one-cycle pulse
mem_addr  output  32  word-aligned read address {daddr[31:2],2'b00}
mem_rvalid  input  1  memory read data valid
mem_rdata  input  32  memory read data (little-endian word)
resp_valid  output  1  response valid
resp_ready  input  1  writeback accepts response
resp_data  output  32  extended load result
resp_rd  output  5  destination register
resp_err  output  1  load faulted
resp_err_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none

Behaviour:
- Reset: async on rst high, regardless of state.
  - State goes to IDLE.
  - mem_re, mem_addr, resp_valid, resp_data, resp_rd, resp_err, resp_err_code and the timeout counter all go to 0.
  - req_ready = 0 while rst is high.
  - A reset mid-operation drops the transaction silently; a late mem_rvalid is then ignored.
- req_ready = (state==IDLE) && !rst, combinational. A request transfers on req_valid && req_ready.
- States: IDLE, WAIT_MEM, RESP.
- IDLE, on transfer:
  - Latch funct3, daddr[1:0] and rd.
  - Check illegal funct3 first: 011, 110 or 111. Go to RESP with err_code 10.
  - Otherwise check misalignment: LH/LHU with daddr[0]=1, or LW with daddr[1:0]!=00. Go to RESP with err_code 01.
  - On either error: no memory access, resp_data=0.
  - Legal request: register mem_addr, pulse mem_re for exactly the next cycle, clear the counter, go to WAIT_MEM.
- WAIT_MEM:
  - mem_rvalid is sampled every cycle, including the cycle mem_re is high, to support zero-latency memory.
  - On mem_rvalid: register the extracted data and go to RESP with err=0.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no mem_rvalid: go to RESP with err_code 11 and resp_data=0.
  - If mem_rvalid arrives on the timeout cycle, the data wins.
- mem_rvalid outside WAIT_MEM is ignored.
- Extraction, with off = latched daddr[1:0]:
  - LB (000): sign-extend mem_rdata[8*off+7 : 8*off].
  - LBU (100): zero-extend the same byte.
  - LH (001): sign-extend mem_rdata[16*off[1]+15 : 16*off[1]].
  - LHU (101): zero-extend the same halfword.
  - LW (010): mem_rdata unchanged.
- RESP:
  - resp_valid=1. resp_data, resp_rd, resp_err and resp_err_code are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE and drop resp_valid next cycle.
  - resp_data/err hold their last values after handshake; only resp_valid qualifies them.
- Throughput: one load in flight; no new request is accepted until the response handshake.
- Latency: request accepted cycle N, mem_re in N+1. If mem_rvalid in N+1, resp_valid in N+2. Error responses: resp_valid in N+1.

Test Plan:
- LB at daddr 0x1003, mem_rdata 0x80FF_1234, resp_ready=1 -> mem_addr 0x1000, one mem_re pulse, resp_data 0xFFFF_FF80, resp_err 0, resp_valid two cycles after accept.
- LBU daddr 0x2001 and LHU daddr 0x2002 with mem_rdata 0x8765_F0A1 -> 0x0000_00F0 and 0x0000_8765. LH at 0x2002 -> 0xFFFF_8765. LW at 0x2000 -> 0x8765_F0A1.
- LW at daddr 0x3002 and LH at 0x3001 -> no mem_re, resp_err 1, code 01, resp_data 0. funct3=011 -> code 10.
- Legal LW, mem_rvalid never asserted, TIMEOUT_CYCLES=16 -> resp_valid with code 11 exactly 16 cycles after mem_re. A late mem_rvalid afterwards is ignored.
- Back-pressure: resp_ready held low 5 cycles -> resp_valid and resp_data stable, req_ready 0. Handshake then req_ready 1 the following cycle.
- Assert rst in WAIT_MEM, then deassert and send mem_rvalid -> outputs 0 immediately, no resp_valid, and the next request completes normally.
